// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser: state encodings, sync marker default
// and the saturating error-count helper.
package uart_pkg;

    localparam logic [7:0] SyncByteDefault = 8'hAA;

    typedef enum logic [2:0] {Sync, Length, Payload, Check, Output} mainState_t;

    typedef enum logic {HsIdle, HsWait} hsState_t;

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_byte_sink.sv
// Receiver-side four-phase handshake: takes one byte per RxReady/RxAck exchange
// and presents it with a single-cycle strobe.
module uart_byte_sink
    import uart_pkg::*;
(
    input  logic       Clk,
    input  logic       nReset,
    input  logic [7:0] RxData,
    input  logic       RxReady,
    input  logic       accept,
    output logic       RxAck,
    output logic       byteStrobe,
    output logic [7:0] byteData
);

    hsState_t hsState;

    // RxAck stays high until the receiver withdraws RxReady, so each byte is captured once
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            hsState    <= HsIdle;
            RxAck      <= 1'b0;
            byteStrobe <= 1'b0;
            byteData   <= '0;
        end else begin
            byteStrobe <= 1'b0;
            case (hsState)
                HsIdle: begin
                    if (RxReady && accept) begin
                        byteData   <= RxData;
                        byteStrobe <= 1'b1;
                        RxAck      <= 1'b1;
                        hsState    <= HsWait;
                    end
                end
                HsWait: begin
                    if (!RxReady) begin
                        RxAck   <= 1'b0;
                        hsState <= HsIdle;
                    end
                end
                default: hsState <= HsIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SYNC/LEN/payload/CHK frames from the UART byte stream and releases the
// payload on a valid/ready stream only once the XOR checksum has matched.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int                    MaxLen   = 16,
    parameter int                    AW       = 4,
    parameter logic [7:0]            SyncByte = SyncByteDefault,
    parameter int                    TimeoutW = 16,
    parameter logic [TimeoutW-1:0]   Timeout  = 16'd50000
) (
    input  logic          Clk,
    input  logic          nReset,
    input  logic [7:0]    RxData,
    input  logic          RxReady,
    output logic          RxAck,
    output logic [7:0]    OutData,
    output logic          OutValid,
    output logic          OutLast,
    input  logic          OutReady,
    output logic [AW:0]   OutLen,
    output logic [7:0]    ErrCount,
    output logic          ErrPulse,
    output logic          Busy
);

    mainState_t          state;
    logic                byteStrobe;
    logic [7:0]          byteData;
    logic [AW:0]         len;
    logic [AW:0]         wp;
    logic [AW-1:0]       rp;
    logic [AW-1:0]       rpNext;
    logic [7:0]          chk;
    logic [TimeoutW-1:0] timer;
    logic [7:0]          payBuf [MaxLen];
    logic                lenOk;
    logic                inFrame;
    logic                errNow;

    uart_byte_sink u_sink (
        .Clk        (Clk),
        .nReset     (nReset),
        .RxData     (RxData),
        .RxReady    (RxReady),
        .accept     (state != Output),
        .RxAck      (RxAck),
        .byteStrobe (byteStrobe),
        .byteData   (byteData)
    );

    always_comb begin
        rpNext  = rp + AW'(1);
        lenOk   = (byteData != 8'd0) && (32'(byteData) <= MaxLen);
        inFrame = (state == Length) || (state == Payload) || (state == Check);
        errNow  = 1'b0;
        if (byteStrobe && state == Length && !lenOk)
            errNow = 1'b1;
        if (byteStrobe && state == Check && byteData != chk)
            errNow = 1'b1;
        // a byte arriving on the timeout cycle takes priority over the timeout
        if (!byteStrobe && inFrame && timer == Timeout)
            errNow = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (byteStrobe && state == Payload)
            payBuf[wp[AW-1:0]] <= byteData;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state    <= Sync;
            len      <= '0;
            wp       <= '0;
            rp       <= '0;
            chk      <= '0;
            timer    <= '0;
            OutData  <= '0;
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
            OutLen   <= '0;
            ErrCount <= '0;
            ErrPulse <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            ErrPulse <= errNow;
            if (errNow) begin
                ErrCount <= satInc(ErrCount);
                state    <= Sync;
                Busy     <= 1'b0;
            end
            case (state)
                Sync: begin
                    if (byteStrobe && byteData == SyncByte) begin
                        state <= Length;
                        Busy  <= 1'b1;
                        timer <= '0;
                    end
                end
                Length, Payload, Check: begin
                    if (byteStrobe) begin
                        timer <= '0;
                        if (state == Length && lenOk) begin
                            len   <= byteData[AW:0];
                            wp    <= '0;
                            chk   <= byteData;
                            state <= Payload;
                        end else if (state == Payload) begin
                            wp  <= wp + (AW+1)'(1);
                            chk <= chk ^ byteData;
                            if (wp + (AW+1)'(1) == len)
                                state <= Check;
                        end else if (state == Check && byteData == chk) begin
                            rp       <= '0;
                            OutValid <= 1'b1;
                            OutData  <= payBuf[0];
                            OutLast  <= (len == (AW+1)'(1));
                            OutLen   <= len;
                            state    <= Output;
                        end
                    end else if (timer != Timeout) begin
                        timer <= timer + TimeoutW'(1);
                    end
                end
                Output: begin
                    if (OutReady) begin
                        if (OutLast) begin
                            OutValid <= 1'b0;
                            OutLast  <= 1'b0;
                            state    <= Sync;
                            Busy     <= 1'b0;
                        end else begin
                            rp      <= rpNext;
                            OutData <= payBuf[rpNext];
                            OutLast <= (({1'b0, rp} + (AW+1)'(2)) == len);
                        end
                    end
                end
                default: state <= Sync;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: acts as the UART receiver and compares
// the payload stream and error counters against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_frame_parser;

    logic       Clk = 1'b0;
    logic       nReset = 1'b0;
    logic [7:0] RxData = 8'h00;
    logic       RxReady = 1'b0;
    logic       RxAck;
    logic [7:0] OutData;
    logic       OutValid;
    logic       OutLast;
    logic       OutReady = 1'b1;
    logic [4:0] OutLen;
    logic [7:0] ErrCount;
    logic       ErrPulse;
    logic       Busy;

    always #5 Clk = ~Clk;

    uart_frame_parser #(
        .MaxLen(16), .AW(4), .SyncByte(8'hAA), .TimeoutW(16), .Timeout(16'd100)
    ) dut (
        .Clk(Clk), .nReset(nReset), .RxData(RxData), .RxReady(RxReady), .RxAck(RxAck),
        .OutData(OutData), .OutValid(OutValid), .OutLast(OutLast), .OutReady(OutReady),
        .OutLen(OutLen), .ErrCount(ErrCount), .ErrPulse(ErrPulse), .Busy(Busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [4:0] len;
    } outBeat_t;

    outBeat_t   expQ[$];
    logic [7:0] obsQ[$];
    logic [7:0] mPay[$];
    int         nCompared = 0;
    int         nMismatch = 0;
    int         mPhase = 0;
    int         mLen = 0;
    int         mErr = 0;
    int         pulses = 0;
    logic       prevPulse = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: phases are hunt-sync, expect-length, collect, expect-checksum
    task automatic modelByte(input logic [7:0] b);
        logic [7:0] x;
        case (mPhase)
            0: if (b == 8'hAA) mPhase = 1;
            1: begin
                if (b >= 8'd1 && b <= 8'd16) begin
                    mLen = int'(b);
                    mPay.delete();
                    mPhase = 2;
                end else begin
                    if (mErr < 255) mErr++;
                    mPhase = 0;
                end
            end
            2: begin
                mPay.push_back(b);
                if (mPay.size() == mLen) mPhase = 3;
            end
            default: begin
                x = 8'(mLen);
                foreach (mPay[i]) x = x ^ mPay[i];
                if (b == x) begin
                    foreach (mPay[i]) expQ.push_back('{mPay[i], (i == mLen - 1), 5'(mLen)});
                end else if (mErr < 255) begin
                    mErr++;
                end
                mPhase = 0;
            end
        endcase
    endtask

    task automatic modelReset();
        mPhase = 0;
        mErr = 0;
        pulses = 0;
        expQ.delete();
        mPay.delete();
    endtask

    task automatic waitAck(input logic lvl, input string name);
        int n = 0;
        while (RxAck !== lvl && n < 400) begin
            @(posedge Clk); #1;
            n++;
        end
        if (RxAck !== lvl) checkOutput(name, RxAck, lvl);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge Clk); #1;
        RxData = b;
        RxReady = 1'b1;
        waitAck(1'b1, "RxAck rise timeout");
        if (RxAck === 1'b1) modelByte(b);
        RxReady = 1'b0;
        waitAck(1'b0, "RxAck fall timeout");
    endtask

    task automatic sendFrame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) applyStimulus(bytes[i]);
    endtask

    task automatic settle(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge Clk);
            n++;
        end
        checkOutput({name, " drained"}, expQ.size(), 0);
        repeat (5) @(negedge Clk);
        checkOutput({name, " ErrCount"}, ErrCount, mErr);
        checkOutput({name, " ErrPulse count"}, pulses, mErr);
        checkOutput({name, " Busy idle"}, Busy, 1'b0);
    endtask

    // Every-cycle compare of the payload stream against the model queue
    always @(negedge Clk) begin
        if (nReset) begin
            if (ErrPulse) begin
                pulses++;
                checkOutput("ErrPulse single cycle", prevPulse, 1'b0);
            end
            prevPulse = ErrPulse;
            if (OutValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected OutValid", OutValid, 1'b0);
                end else begin
                    checkOutput("OutData", OutData, expQ[0].data);
                    checkOutput("OutLast", OutLast, expQ[0].last);
                    checkOutput("OutLen", OutLen, expQ[0].len);
                    if (OutReady) begin
                        obsQ.push_back(OutData);
                        void'(expQ.pop_front());
                    end
                end
            end
        end else begin
            prevPulse = 1'b0;
        end
    end

    task automatic checkResetOutputs(input string name);
        checkOutput({name, " RxAck"}, RxAck, 0);
        checkOutput({name, " OutValid"}, OutValid, 0);
        checkOutput({name, " OutLast"}, OutLast, 0);
        checkOutput({name, " ErrPulse"}, ErrPulse, 0);
        checkOutput({name, " Busy"}, Busy, 0);
        checkOutput({name, " OutData"}, OutData, 0);
        checkOutput({name, " OutLen"}, OutLen, 0);
        checkOutput({name, " ErrCount"}, ErrCount, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge Clk);
        #1;
        checkResetOutputs("reset");
        nReset = 1'b1;

        $display("[TB] good frame");
        sendFrame('{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        settle("good frame");
        checkOutput("good frame size", obsQ.size(), 3);
        if (obsQ.size() == 3) begin
            checkOutput("good frame byte0", obsQ[0], 8'h11);
            checkOutput("good frame byte1", obsQ[1], 8'h22);
            checkOutput("good frame byte2", obsQ[2], 8'h33);
        end
        checkOutput("good frame ErrCount literal", ErrCount, 8'd0);

        $display("[TB] bad checksum");
        sendFrame('{8'hAA, 8'h02, 8'h10, 8'h20, 8'h00});
        settle("bad checksum");
        checkOutput("bad checksum ErrCount literal", ErrCount, 8'd1);
        checkOutput("bad checksum no output", obsQ.size(), 3);

        $display("[TB] bad lengths");
        sendFrame('{8'hAA, 8'h00, 8'hAA, 8'h11, 8'hAA, 8'h01, 8'h5A, 8'h5B});
        settle("bad lengths");
        checkOutput("bad lengths ErrCount literal", ErrCount, 8'd3);
        checkOutput("bad lengths payload", obsQ[obsQ.size()-1], 8'h5A);

        $display("[TB] garbage then frame");
        sendFrame('{8'h55, 8'h13, 8'hAA, 8'h01, 8'h7E, 8'h7F});
        settle("garbage");
        checkOutput("garbage ErrCount literal", ErrCount, 8'd3);
        checkOutput("garbage payload", obsQ[obsQ.size()-1], 8'h7E);

        $display("[TB] timeout");
        sendFrame('{8'hAA, 8'h04, 8'h11});
        repeat (50) @(negedge Clk);
        checkOutput("timeout Busy mid-frame", Busy, 1'b1);
        checkOutput("timeout not yet fired", ErrCount, 8'd3);
        repeat (70) @(negedge Clk);
        mErr++;
        mPhase = 0;
        settle("timeout");
        checkOutput("timeout ErrCount literal", ErrCount, 8'd4);
        sendFrame('{8'hAA, 8'h02, 8'hC3, 8'h3C, 8'hFD});
        settle("after timeout");
        checkOutput("after timeout payload", obsQ[obsQ.size()-1], 8'h3C);

        $display("[TB] backpressure");
        @(posedge Clk); #1;
        OutReady = 1'b0;
        sendFrame('{8'hAA, 8'h01, 8'h44, 8'h45});
        n = 0;
        while (!OutValid && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        checkOutput("backpressure OutValid", OutValid, 1'b1);
        RxData = 8'hAA;
        RxReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            checkOutput("backpressure RxAck held", RxAck, 1'b0);
            checkOutput("backpressure OutData stable", OutData, 8'h44);
        end
        @(posedge Clk); #1;
        OutReady = 1'b1;
        waitAck(1'b1, "backpressure ack after drain");
        if (RxAck === 1'b1) modelByte(8'hAA);
        RxReady = 1'b0;
        waitAck(1'b0, "backpressure ack fall");
        sendFrame('{8'h02, 8'h01, 8'h02, 8'h01});
        settle("backpressure");
        checkOutput("backpressure last payload", obsQ[obsQ.size()-1], 8'h02);

        $display("[TB] reset mid-payload");
        sendFrame('{8'hAA, 8'h03, 8'h11});
        @(posedge Clk); #1;
        RxData = 8'h22;
        RxReady = 1'b1;
        waitAck(1'b1, "pre-reset ack");
        #2;
        nReset = 1'b0;
        #1;
        checkResetOutputs("mid reset");
        modelReset();
        repeat (2) @(posedge Clk);
        #1;
        nReset = 1'b1;
        waitAck(1'b1, "re-handshake after reset");
        if (RxAck === 1'b1) modelByte(8'h22);
        RxReady = 1'b0;
        waitAck(1'b0, "re-handshake fall");
        sendFrame('{8'hAA, 8'h01, 8'h5A, 8'h5B});
        settle("post reset");
        checkOutput("post reset ErrCount literal", ErrCount, 8'd0);
        checkOutput("post reset payload", obsQ[obsQ.size()-1], 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
